// File: rtl/warmboot_pkg.sv
// Shared types and constants for the SB_WARMBOOT sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package warmboot_pkg;

  // Sequencer state encoding; HOLD is terminal until reset.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    FIRE  = 2'd2,
    HOLD  = 2'd3
  } wb_state_t;

  // SB_WARMBOOT addresses up to four images through S1/S0.
  localparam int IMG_W = 2;

  // One second of idle time at the 12 MHz board clock.
  localparam int TIMEOUT_12MHZ = 12_000_000;

  // Bits needed to count 0 .. n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/warmboot_sequencer_if.sv
// Boot request/ack bus between the bootloader core and the sequencer.
// Latency: n/a (wires only); the sequencer answers a request one cycle later.
// Backpressure: none; requests made while busy are dropped by the sequencer.
interface warmboot_sequencer_if;
  import warmboot_pkg::*;

  logic             boot_req;
  logic [IMG_W-1:0] boot_img;
  logic             boot_ack;
  logic             img_err;
  logic             busy;

  // Bootloader side: issues requests, observes the response.
  modport master (
    output boot_req,
    output boot_img,
    input  boot_ack,
    input  img_err,
    input  busy
  );

  // Sequencer side.
  modport slave (
    input  boot_req,
    input  boot_img,
    output boot_ack,
    output img_err,
    output busy
  );

endinterface

// File: rtl/wb_timeout_counter.sv
// Loadable, clearable up-counter with a compare-to-limit expire strobe.
// Latency: expire is combinational from the current count and inc.
// Backpressure: none; the count stops at limit until cleared or loaded.
module wb_timeout_counter #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic         expire
);

  logic [W-1:0] count;

  // Expire does not look at clear so callers can wrap by clearing on expire.
  assign expire = inc && (count == limit);

  // Count register: clear beats load beats increment; never passes limit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc && (count != limit)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/warmboot_sequencer.sv
// iCE40 SB_WARMBOOT controller: image select, req/ack, S1/S0 setup time, idle auto-boot.
// Latency: ack and S1/S0 one cycle after boot_req; wb_boot SETUP_CYCLES cycles after that.
// Backpressure: none; requests and activity while busy are ignored. Optional WARMBOOT_STATUS_LED_EN adds led.
module warmboot_sequencer
  import warmboot_pkg::*;
#(
  parameter int NUM_IMAGES     = 4,
  parameter int DEFAULT_IMAGE  = 1,
  parameter int TIMEOUT_CYCLES = TIMEOUT_12MHZ,
  parameter int SETUP_CYCLES   = 4,
  parameter int CNT_W          = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  warmboot_sequencer_if.slave  bus,
  input  logic                 activity,
  input  logic                 timeout_en,
  output logic                 wb_s1,
  output logic                 wb_s0,
  output logic                 wb_boot
`ifdef WARMBOOT_STATUS_LED_EN
  ,
  output logic                 led
`endif
);

  localparam bit                TO_ENABLED = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0]  TO_LIMIT   = TO_ENABLED ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam int                SC_W       = cnt_width(SETUP_CYCLES);
  localparam logic [SC_W-1:0]   SC_LIMIT   = SC_W'(SETUP_CYCLES - 1);
  localparam logic [IMG_W-1:0]  DEF_IMG    = IMG_W'(DEFAULT_IMAGE);

  wb_state_t        state_q, state_d;
  logic [IMG_W-1:0] img_q, img_d;
  logic             ack_d, err_d;
  logic             ack_q, err_q, busy_q, s1_q, s0_q, boot_q;
  logic             img_valid;
  logic             to_active, to_clear, to_inc, to_expire;
  logic             sc_clear, sc_inc, sc_expire;

  assign img_valid = (int'(bus.boot_img) < NUM_IMAGES);

  // Idle timeout runs only in IDLE; activity or disable restart it, a
  // rejected request freezes it for that cycle.
  assign to_active = (state_q == IDLE) && timeout_en && TO_ENABLED;
  assign to_clear  = !to_active || activity;
  assign to_inc    = to_active && !activity && !bus.boot_req;

  wb_timeout_counter #(.W(CNT_W)) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clear    (to_clear),
    .load     (1'b0),
    .load_val ('0),
    .inc      (to_inc),
    .limit    (TO_LIMIT),
    .expire   (to_expire)
  );

  // Same counter block times the S1/S0 setup window.
  assign sc_clear = (state_q != SETUP);
  assign sc_inc   = (state_q == SETUP);

  wb_timeout_counter #(.W(SC_W)) u_setup (
    .clk      (clk),
    .reset    (reset),
    .clear    (sc_clear),
    .load     (1'b0),
    .load_val ('0),
    .inc      (sc_inc),
    .limit    (SC_LIMIT),
    .expire   (sc_expire)
  );

  // Next state and image; a request in the expiry cycle wins over the timeout.
  always_comb begin
    state_d = state_q;
    img_d   = img_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.boot_req) begin
          if (img_valid) begin
            img_d   = bus.boot_img;
            state_d = SETUP;
            ack_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (to_expire) begin
          img_d   = DEF_IMG;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (sc_expire) begin
          state_d = FIRE;
        end
      end
      FIRE: state_d = HOLD;
      HOLD: state_d = HOLD;
    endcase
  end

  // State and outputs registered from the next-state decode.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      img_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      s1_q    <= 1'b0;
      s0_q    <= 1'b0;
      boot_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      img_q   <= img_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= (state_d != IDLE);
      s1_q    <= (state_d != IDLE) && img_d[1];
      s0_q    <= (state_d != IDLE) && img_d[0];
      boot_q  <= (state_d == FIRE) || (state_d == HOLD);
    end
  end

  assign bus.boot_ack = ack_q;
  assign bus.img_err  = err_q;
  assign bus.busy     = busy_q;
  assign wb_s1        = s1_q;
  assign wb_s0        = s0_q;
  assign wb_boot      = boot_q;

`ifdef WARMBOOT_STATUS_LED_EN
  localparam int               BLINK_CYCLES = ((TIMEOUT_CYCLES >> 4) < 1) ? 1 : (TIMEOUT_CYCLES >> 4);
  localparam logic [CNT_W-1:0] BL_LIMIT     = CNT_W'(BLINK_CYCLES - 1);

  logic bl_expire;
  logic led_q;

  // Blink period counter wraps on its own expire and restarts with the timeout.
  wb_timeout_counter #(.W(CNT_W)) u_blink (
    .clk      (clk),
    .reset    (reset),
    .clear    (to_clear || bl_expire),
    .load     (1'b0),
    .load_val ('0),
    .inc      (to_active && !activity),
    .limit    (BL_LIMIT),
    .expire   (bl_expire)
  );

  // Led: off once booting, steady on when no timeout is armed, else blinking.
  always_ff @(posedge clk) begin
    if (!reset) begin
      led_q <= 1'b0;
    end else if (state_d != IDLE) begin
      led_q <= 1'b0;
    end else if (!to_active) begin
      led_q <= 1'b1;
    end else if (activity) begin
      led_q <= 1'b0;
    end else if (bl_expire) begin
      led_q <= ~led_q;
    end
  end

  assign led = led_q;
`endif

endmodule

// File: tb/tb_warmboot_sequencer.sv
// Bench for warmboot_sequencer: a 4-image and a 3-image instance share stimulus.
// Latency: checks every cycle on the falling edge against a cycle-level model.
// Backpressure: n/a.
module tb_warmboot_sequencer;
  import warmboot_pkg::*;

  localparam int T   = 100;
  localparam int S   = 4;
  localparam int DEF = 1;

  logic       clk;
  logic       reset;
  logic       boot_req;
  logic [1:0] boot_img;
  logic       activity;
  logic       timeout_en;
  logic       s1_4, s0_4, boot_4;
  logic       s1_3, s0_3, boot_3;
`ifdef WARMBOOT_STATUS_LED_EN
  logic       led_4, led_3;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  warmboot_sequencer_if bus4 ();
  warmboot_sequencer_if bus3 ();

  assign bus4.boot_req = boot_req;
  assign bus4.boot_img = boot_img;
  assign bus3.boot_req = boot_req;
  assign bus3.boot_img = boot_img;

  warmboot_sequencer #(
    .NUM_IMAGES(4), .DEFAULT_IMAGE(DEF), .TIMEOUT_CYCLES(T), .SETUP_CYCLES(S), .CNT_W(24)
  ) u_dut4 (
    .clk(clk), .reset(reset), .bus(bus4), .activity(activity), .timeout_en(timeout_en),
    .wb_s1(s1_4), .wb_s0(s0_4), .wb_boot(boot_4)
`ifdef WARMBOOT_STATUS_LED_EN
    , .led(led_4)
`endif
  );

  warmboot_sequencer #(
    .NUM_IMAGES(3), .DEFAULT_IMAGE(DEF), .TIMEOUT_CYCLES(T), .SETUP_CYCLES(S), .CNT_W(24)
  ) u_dut3 (
    .clk(clk), .reset(reset), .bus(bus3), .activity(activity), .timeout_en(timeout_en),
    .wb_s1(s1_3), .wb_s0(s0_3), .wb_boot(boot_3)
`ifdef WARMBOOT_STATUS_LED_EN
    , .led(led_3)
`endif
  );

  // Reference model, index 0 = 4-image instance, 1 = 3-image instance.
  // booted: boot in progress; since: cycles since ack/S1S0 first appeared;
  // idle_run: consecutive qualifying idle cycles toward the timeout.
  int booted[2], since[2], img[2], exp_ack[2], exp_err[2], idle_run[2];
  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  function automatic int nimg(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      exp_ack[d] = 0;
      exp_err[d] = 0;
      if (!reset) begin
        booted[d] = 0; since[d] = 0; img[d] = 0; idle_run[d] = 0;
      end else if (booted[d] != 0) begin
        since[d]++;
      end else if (boot_req && int'(boot_img) < nimg(d)) begin
        booted[d] = 1; since[d] = 0; img[d] = int'(boot_img); exp_ack[d] = 1;
      end else begin
        if (boot_req) exp_err[d] = 1;
        if (!timeout_en || activity) begin
          idle_run[d] = 0;
        end else if (!boot_req) begin
          idle_run[d]++;
          if (idle_run[d] == T) begin
            booted[d] = 1; since[d] = 0; img[d] = DEF;
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, expv);
    end
  endtask

  task automatic check_all();
    chk("d4.boot_ack", bus4.boot_ack, exp_ack[0] != 0);
    chk("d4.img_err",  bus4.img_err,  exp_err[0] != 0);
    chk("d4.busy",     bus4.busy,     booted[0] != 0);
    chk("d4.wb_s1",    s1_4,          booted[0] != 0 && (img[0] & 2) != 0);
    chk("d4.wb_s0",    s0_4,          booted[0] != 0 && (img[0] & 1) != 0);
    chk("d4.wb_boot",  boot_4,        booted[0] != 0 && since[0] >= S);
    chk("d3.boot_ack", bus3.boot_ack, exp_ack[1] != 0);
    chk("d3.img_err",  bus3.img_err,  exp_err[1] != 0);
    chk("d3.busy",     bus3.busy,     booted[1] != 0);
    chk("d3.wb_s1",    s1_3,          booted[1] != 0 && (img[1] & 2) != 0);
    chk("d3.wb_s0",    s0_3,          booted[1] != 0 && (img[1] & 1) != 0);
    chk("d3.wb_boot",  boot_3,        booted[1] != 0 && since[1] >= S);
  endtask

  // One clock: check current outputs, advance the model with current inputs.
  task automatic step();
    @(negedge clk);
    check_all();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
    cyc = 0;
  endtask

  task automatic request(input logic [1:0] im);
    boot_req = 1'b1;
    boot_img = im;
    step();
    boot_req = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      booted[d] = 0; since[d] = 0; img[d] = 0; exp_ack[d] = 0; exp_err[d] = 0; idle_run[d] = 0;
    end
    reset = 1'b0; boot_req = 1'b0; boot_img = 2'd0; activity = 1'b0; timeout_en = 1'b0;
    @(posedge clk);
    #1;

    // Reset values.
    repeat (2) step();
    reset = 1'b1; timeout_en = 1'b1; cyc = 0;

    // Request image 2 at cycle 10: ack at 11, S1S0=10 from 11, boot from 15.
    repeat (10) step();
    request(2'd2);
    repeat (20) step();

    // Image 3: rejected by 3-image unit, accepted by 4-image unit; then image 0.
    do_reset();
    repeat (3) step();
    request(2'd3);
    repeat (3) step();
    request(2'd0);
    repeat (10) step();

    // Pure timeout: default image, no ack.
    do_reset();
    repeat (110) step();

    // Activity at cycle 90 restarts the timeout.
    do_reset();
    repeat (90) step();
    activity = 1'b1; step(); activity = 1'b0;
    repeat (120) step();

    // Timeout disabled for 500 cycles, then re-enabled.
    do_reset();
    timeout_en = 1'b0;
    repeat (500) step();
    timeout_en = 1'b1;
    repeat (110) step();

    // Request coincident with expiry, then a request during SETUP.
    do_reset();
    repeat (99) step();
    request(2'd3);
    repeat (2) step();
    request(2'd1);
    repeat (8) step();

    // Reset during SETUP and during HOLD.
    do_reset();
    request(2'd2);
    repeat (2) step();
    do_reset();
    repeat (3) step();
    request(2'd1);
    repeat (8) step();
    do_reset();
    repeat (5) step();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 59) != 0);
      boot_req = ($urandom_range(0, 24) == 0);
      boot_img = 2'($urandom_range(0, 3));
      activity = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 199) == 0) timeout_en = ~timeout_en;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/warmboot_sequencer.md
Name: warmboot_sequencer

Overview:
Parametrised controller for the iCE40 SB_WARMBOOT primitive. It replaces the hard-tied S1/S0 and the bare boot strobe with image selection, a request/ack handshake and a guaranteed select-setup interval. It also provides an optional inactivity timeout that auto-boots a default image. It sits in the board top between the bootloader core and SB_WARMBOOT, in the 12 MHz clk domain.

Parameters:
NUM_IMAGES, 4, number of selectable images (2..4); boot_img >= NUM_IMAGES is invalid
DEFAULT_IMAGE, 1, image used on timeout; must be < NUM_IMAGES
TIMEOUT_CYCLES, 12000000, idle cycles before auto-boot (1 s at 12 MHz); 0 disables the timeout permanently
SETUP_CYCLES, 4, cycles S1/S0 are held stable before wb_boot rises (>= 1)
CNT_W, 24, timeout counter width; must hold TIMEOUT_CYCLES

Ports:
clk  input  1  system clock (12 MHz)
reset  input  1  synchronous, active-low reset (reset==0 resets on the clk edge)
boot_req  input  1  single-cycle boot request
boot_img  input  2  requested image, sampled when boot_req==1
boot_ack  output  1  one-cycle pulse: request accepted
img_err  output  1  one-cycle pulse: request rejected (boot_img >= NUM_IMAGES)
activity  input  1  host activity strobe; restarts the timeout
timeout_en  input  1  level; 0 freezes and clears the timeout counter
wb_s1  output  1  to SB_WARMBOOT.S1
wb_s0  output  1  to SB_WARMBOOT.S0
wb_boot  output  1  to SB_WARMBOOT.BOOT
busy  output  1  1 in any state other than IDLE

Behaviour:
- Reset values: state=IDLE; wb_s1=0, wb_s0=0, wb_boot=0, boot_ack=0, img_err=0, busy=0; counters=0; latched image=0.
- All outputs are registered.
- States:
  - IDLE:
    - boot_req with valid img: latch img, pulse boot_ack on the next cycle, go to SETUP.
    - boot_req with invalid img: pulse img_err on the next cycle, stay in IDLE, timeout counter unaffected.
    - Otherwise, when timeout_en=1 and TIMEOUT_CYCLES!=0, the counter increments each cycle. activity=1 or timeout_en=0 clears it to 0.
    - Counter reaching TIMEOUT_CYCLES-1: latch DEFAULT_IMAGE, go to SETUP. No boot_ack is issued for a timeout boot.
  - SETUP: wb_s1/wb_s0 = latched image bits [1]/[0], driven from the first SETUP cycle. Hold for exactly SETUP_CYCLES cycles, then go to FIRE.
  - FIRE: wb_boot=1 while S1/S0 are held. Next state is HOLD.
  - HOLD: wb_boot, S1 and S0 stay asserted. The state is terminal; only reset exits it.
- Latency: boot_req at cycle N gives boot_ack and busy=1 at N+1, S1/S0 valid at N+1, and wb_boot=1 at N+1+SETUP_CYCLES.
- Boundaries:
  - boot_req and timeout expiry in the same cycle: the request wins (its image is used and boot_ack pulses).
  - activity and expiry in the same cycle: activity wins, counter cleared, no boot.
  - boot_req or activity while busy: ignored, no ack, no err.
  - reset=0 in any state, including mid-SETUP or HOLD: all outputs go to their reset values on the next edge.
  - The counter saturates conceptually; it never wraps because expiry leaves IDLE.

Optional Feature:
WARMBOOT_STATUS_LED_EN
- Defined: adds port led (output, 1, reset 0).
  - In IDLE with timeout active, led toggles every max(1, TIMEOUT_CYCLES>>4) cycles (about 8 blinks per timeout), restarting at 0 on activity.
  - In IDLE with timeout inactive, led=1.
  - In SETUP, FIRE and HOLD, led=0.
- Undefined: no led port and no blink logic; core behaviour is identical.

Decomposition:
- Shared package warmboot_pkg:
  - state encoding constants: IDLE=2'd0, SETUP=2'd1, FIRE=2'd2, HOLD=2'd3
  - image width constant (2)
  - default timeout constant for 12 MHz
- One natural sub-module: wb_timeout_counter (loadable, clearable cycle counter with expire pulse). It is reused for both the timeout and the SETUP count.

Test Plan:
- Bench parameters: TIMEOUT_CYCLES=100, SETUP_CYCLES=4, NUM_IMAGES=4, DEFAULT_IMAGE=1.
- boot_req=1, boot_img=2 at cycle 10 -> boot_ack=1 at cycle 11 only; {wb_s1,wb_s0}=2'b10 from 11; wb_boot=1 from 15 and held.
- NUM_IMAGES=3, boot_req with boot_img=3 -> img_err pulses 1 cycle, busy=0, wb_* stay 0; a following boot_img=0 request is accepted.
- timeout_en=1, no activity -> at cycle 100 enters SETUP with {s1,s0}=2'b01, wb_boot=1 four cycles later, boot_ack never pulses.
- activity pulse at cycle 90, then idle -> no boot until 100 cycles after the pulse; with timeout_en=0 for 500 cycles -> no boot.
- boot_req (img 3) coincident with timeout expiry -> {s1,s0}=2'b11 and boot_ack pulses; a second boot_req during SETUP is ignored.
- reset=0 for 1 cycle during SETUP and again during HOLD -> all outputs return to 0 on the next edge, state IDLE, counter restarts.
